// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman bit packing stage.
package huffman_pkg;

    localparam int   CODE_W  = 64;
    localparam int   SIZE_W  = $clog2(CODE_W) + 1;
    localparam int   ACC_W   = 2 * CODE_W;
    localparam int   FILL_W  = 8;
    localparam logic PAD_BIT = 1'b1;

    // One variable-length code; code[size-1:0] is meaningful, bit size-1 goes first.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [SIZE_W-1:0] size;
        logic              sop;
        logic              eop;
        logic              valid;
        logic              done;
    } HuffmanBus_t;

    // Packed output word; data[CODE_W-1] is the first bit in stream order.
    typedef struct packed {
        logic [CODE_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              valid;
    } fixedLength_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } packer_state_t;

    // Number of bytes needed to hold 'bits' bits (0..64).
    function automatic logic [3:0] byte_count(input logic [6:0] bits);
        return bits[6:3] + {3'b000, |bits[2:0]};
    endfunction

endpackage

// File: rtl/huffman_bit_packer_bit_align_append.sv
// Combinational append of one code into the MSB-aligned accumulator at
// position 'fill'. Oversized codes are clamped to CODE_W bits and bits of
// 'code' above 'size' are masked off so stale upper bits never leak in.
module bit_align_append
    import huffman_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    input  logic [FILL_W-1:0] fill,
    input  logic [CODE_W-1:0] code,
    input  logic [SIZE_W-1:0] size,
    output logic [ACC_W-1:0]  new_acc,
    output logic [FILL_W-1:0] new_fill
);

    logic [SIZE_W-1:0] size_c;
    logic [CODE_W-1:0] mask;
    logic [ACC_W-1:0]  aligned;

    assign size_c = (size > SIZE_W'(CODE_W)) ? SIZE_W'(CODE_W) : size;

    // Keep only the low size_c bits of the code.
    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_mask
        assign mask[gi] = (SIZE_W'(gi) < size_c);
    end

    // Move the code's first bit to the accumulator MSB, then down to 'fill'.
    assign aligned  = {code & mask, {CODE_W{1'b0}}} << (SIZE_W'(CODE_W) - size_c);
    assign new_acc  = acc | (aligned >> fill);
    assign new_fill = fill + {1'b0, size_c};

endmodule

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codes MSB-first into 64-bit words, framing
// with sop/eop, padding the final word and reporting its valid byte count.
module huffman_bit_packer
    import huffman_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  HuffmanBus_t  in_i,
    output fixedLength_t out_o,
    output logic [3:0]   eop_bytes_o,
    output logic         done_o,
    output logic         err_o
);

    packer_state_t     state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [CODE_W-1:0] flush_word_reg, flush_word_next;
    logic [3:0]        flush_bytes_reg, flush_bytes_next;
    logic              flush_done_reg, flush_done_next;
    logic              flush_sop_reg, flush_sop_next;
    logic              sop_pending_reg, sop_pending_next;
    fixedLength_t      out_reg, out_next;
    logic [3:0]        eop_bytes_reg, eop_bytes_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic [ACC_W-1:0]  base_acc, app_acc;
    logic [FILL_W-1:0] base_fill, app_fill, res_fill;
    logic [CODE_W-1:0] eop_word, res_word;
    logic [3:0]        eop_bytes, res_bytes;
    logic              sop_open;

    // A sop always starts from an empty accumulator (discarding any open frame).
    assign base_acc  = in_i.sop ? '0 : acc_reg;
    assign base_fill = in_i.sop ? '0 : fill_reg;

    bit_align_append u_append (
        .acc      (base_acc),
        .fill     (base_fill),
        .code     (in_i.code),
        .size     (in_i.size),
        .new_acc  (app_acc),
        .new_fill (app_fill)
    );

    assign sop_open  = in_i.sop | sop_pending_reg;
    assign res_fill  = app_fill - FILL_W'(CODE_W);
    assign eop_word  = app_acc[ACC_W-1:CODE_W] | ({CODE_W{PAD_BIT}} & ({CODE_W{1'b1}} >> app_fill));
    assign res_word  = app_acc[CODE_W-1:0]     | ({CODE_W{PAD_BIT}} & ({CODE_W{1'b1}} >> res_fill));
    assign eop_bytes = byte_count(app_fill[6:0]);
    assign res_bytes = byte_count(res_fill[6:0]);

    // Next-state, emit decision and output word selection.
    always_comb begin
        state_next       = state_reg;
        acc_next         = acc_reg;
        fill_next        = fill_reg;
        flush_word_next  = flush_word_reg;
        flush_bytes_next = flush_bytes_reg;
        flush_done_next  = flush_done_reg;
        flush_sop_next   = flush_sop_reg;
        sop_pending_next = sop_pending_reg;
        out_next         = '0;
        eop_bytes_next   = '0;
        done_next        = 1'b0;
        err_next         = 1'b0;

        // Residual word of a split eop leaves this cycle.
        if (state_reg == FLUSH) begin
            out_next.data  = flush_word_reg;
            out_next.valid = 1'b1;
            out_next.eop   = 1'b1;
            out_next.sop   = flush_sop_reg;
            eop_bytes_next = flush_bytes_reg;
            done_next      = flush_done_reg;
            flush_sop_next = 1'b0;
            state_next     = IDLE;
        end

        if (in_i.valid) begin
            if (!in_i.sop && state_reg != ACTIVE) begin
                // Data outside any frame is dropped.
                err_next = 1'b1;
            end else begin
                if (in_i.sop && state_reg == ACTIVE)
                    err_next = 1'b1;

                if (!in_i.eop) begin
                    state_next = ACTIVE;
                    if (app_fill > FILL_W'(CODE_W)) begin
                        out_next.data    = app_acc[ACC_W-1:CODE_W];
                        out_next.valid   = 1'b1;
                        out_next.sop     = sop_open;
                        sop_pending_next = 1'b0;
                        acc_next         = {app_acc[CODE_W-1:0], {CODE_W{1'b0}}};
                        fill_next        = res_fill;
                    end else begin
                        sop_pending_next = sop_open;
                        acc_next         = app_acc;
                        fill_next        = app_fill;
                    end
                end else if (app_fill <= FILL_W'(CODE_W)) begin
                    acc_next         = '0;
                    fill_next        = '0;
                    sop_pending_next = 1'b0;
                    if (state_reg == FLUSH) begin
                        // Output slot is taken by the residual; hold this word one cycle.
                        flush_word_next  = eop_word;
                        flush_bytes_next = eop_bytes;
                        flush_done_next  = in_i.done;
                        flush_sop_next   = sop_open;
                        state_next       = FLUSH;
                    end else begin
                        out_next.data  = eop_word;
                        out_next.valid = 1'b1;
                        out_next.eop   = 1'b1;
                        out_next.sop   = sop_open;
                        eop_bytes_next = eop_bytes;
                        done_next      = in_i.done;
                        state_next     = IDLE;
                    end
                end else begin
                    // Split eop: top word now, residual from the flush register next cycle.
                    out_next.data    = app_acc[ACC_W-1:CODE_W];
                    out_next.valid   = 1'b1;
                    out_next.sop     = sop_open;
                    sop_pending_next = 1'b0;
                    flush_word_next  = res_word;
                    flush_bytes_next = res_bytes;
                    flush_done_next  = in_i.done;
                    flush_sop_next   = 1'b0;
                    acc_next         = '0;
                    fill_next        = '0;
                    state_next       = FLUSH;
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            fill_reg        <= '0;
            flush_word_reg  <= '0;
            flush_bytes_reg <= '0;
            flush_done_reg  <= 1'b0;
            flush_sop_reg   <= 1'b0;
            sop_pending_reg <= 1'b0;
            out_reg         <= '0;
            eop_bytes_reg   <= '0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            acc_reg         <= acc_next;
            fill_reg        <= fill_next;
            flush_word_reg  <= flush_word_next;
            flush_bytes_reg <= flush_bytes_next;
            flush_done_reg  <= flush_done_next;
            flush_sop_reg   <= flush_sop_next;
            sop_pending_reg <= sop_pending_next;
            out_reg         <= out_next;
            eop_bytes_reg   <= eop_bytes_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
        end
    end

    assign out_o       = out_reg;
    assign eop_bytes_o = eop_bytes_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed, table-driven bench for huffman_bit_packer.
module tb_huffman_bit_packer;
    import huffman_pkg::*;

    logic         clk;
    logic         rst_n;
    HuffmanBus_t  in_i;
    fixedLength_t out_o;
    logic [3:0]   eop_bytes_o;
    logic         done_o;
    logic         err_o;

    int n_cmp  = 0;
    int n_fail = 0;

    huffman_bit_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_i        (in_i),
        .out_o       (out_o),
        .eop_bytes_o (eop_bytes_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output packed as {valid, sop, eop, bytes[3:0], done, err, data[63:0]}.
    typedef struct {
        logic        v, sop, eop, done;
        logic [6:0]  size;
        logic [63:0] code;
        logic [72:0] exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [72:0] NONE = '0;

    function automatic logic [72:0] word(input logic sop, input logic eop, input logic [3:0] bytes,
                                         input logic done, input logic err, input logic [63:0] data);
        return {1'b1, sop, eop, bytes, done, err, data};
    endfunction

    function automatic logic [72:0] err_only();
        return {1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 64'd0};
    endfunction

    task automatic add(input logic v, input logic sop, input logic eop, input logic done,
                       input logic [6:0] size, input logic [63:0] code, input logic [72:0] exp);
        vec_t r;
        r.v = v; r.sop = sop; r.eop = eop; r.done = done;
        r.size = size; r.code = code; r.exp = exp;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic v, input logic sop, input logic eop, input logic done,
                         input logic [6:0] size, input logic [63:0] code);
        assert (size <= 7'd64) else $error("stimulus size %0d exceeds code width", size);
        in_i.valid = v;
        in_i.sop   = sop;
        in_i.eop   = eop;
        in_i.done  = done;
        in_i.size  = size;
        in_i.code  = code;
    endtask

    task automatic check(input string name, input logic [72:0] exp);
        logic [72:0] got;
        got = {out_o.valid, out_o.sop, out_o.eop, eop_bytes_o, done_o, err_o, out_o.data};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {v,sop,eop,bytes,done,err,data}=%h required %h", name, got, exp);
        end else begin
            $display("ok   %s: v=%b sop=%b eop=%b bytes=%0d done=%b err=%b data=%h",
                     name, got[72], got[71], got[70], got[69:66], got[65], got[64], got[63:0]);
        end
    endtask

    initial begin
        // Single-word frame; garbage above size must be ignored.
        add(1, 1, 0, 0, 3, 64'hFFFF_FFFF_FFFF_FFF5, NONE);
        add(1, 0, 1, 0, 2, 64'h1, word(1, 1, 4'd1, 0, 0, 64'hAFFF_FFFF_FFFF_FFFF));
        add(0, 0, 0, 0, 0, 64'h0, NONE);
        // Exactly 64 bits: held until eop, no early word.
        add(1, 1, 0, 0, 4, 64'hA, NONE);
        for (int i = 0; i < 14; i++) add(1, 0, 0, 0, 4, 64'hA, NONE);
        add(1, 0, 1, 0, 4, 64'hA, word(1, 1, 4'd8, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA));
        // Split eop.
        add(1, 1, 0, 0, 64, 64'h0123_4567_89AB_CDEF, NONE);
        add(1, 0, 1, 0, 8, 64'h5A, word(1, 0, 4'd0, 0, 0, 64'h0123_4567_89AB_CDEF));
        add(0, 0, 0, 0, 0, 64'h0, word(0, 1, 4'd1, 0, 0, 64'h5AFF_FFFF_FFFF_FFFF));
        // Split eop with done, new sop during the flush cycle.
        add(1, 1, 0, 0, 64, 64'hFEDC_BA98_7654_3210, NONE);
        add(1, 0, 1, 1, 4, 64'h9, word(1, 0, 4'd0, 0, 0, 64'hFEDC_BA98_7654_3210));
        add(1, 1, 0, 0, 1, 64'h0, word(0, 1, 4'd1, 1, 0, 64'h9FFF_FFFF_FFFF_FFFF));
        add(1, 0, 1, 0, 0, 64'h0, word(1, 1, 4'd1, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF));
        // Empty frame with done.
        add(1, 1, 1, 1, 0, 64'h0, word(1, 1, 4'd0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF));
        // Data before any sop is dropped.
        add(1, 0, 0, 0, 8, 64'h12, err_only());
        // sop inside an open frame: old bits discarded.
        add(1, 1, 0, 0, 40, 64'h12_3456_7890, NONE);
        add(1, 1, 1, 0, 8, 64'h3C, word(1, 1, 4'd1, 0, 1, 64'h3CFF_FFFF_FFFF_FFFF));
        add(0, 0, 0, 0, 0, 64'h0, NONE);
        // Non-eop overflow emits mid-frame, residual carried to eop.
        add(1, 1, 0, 0, 60, 64'h0123_4567_89AB_CDEF, NONE);
        add(1, 0, 0, 0, 8, 64'hC3, word(1, 0, 4'd0, 0, 0, 64'h1234_5678_9ABC_DEFC));
        add(1, 0, 1, 0, 0, 64'h0, word(0, 1, 4'd1, 0, 0, 64'h3FFF_FFFF_FFFF_FFFF));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset", NONE);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].sop, vecs[i].eop, vecs[i].done, vecs[i].size, vecs[i].code);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset while a frame is open and a word is on the output.
        drive(1, 1, 0, 0, 64, 64'h1111_2222_3333_4444);
        @(posedge clk); #1;
        check("rst_seq_fill", NONE);
        drive(1, 0, 0, 0, 8, 64'h55);
        @(posedge clk); #1;
        check("rst_seq_word", word(1, 0, 4'd0, 0, 0, 64'h1111_2222_3333_4444));
        drive(0, 0, 0, 0, 0, 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", NONE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_idle%0d", i), NONE);
        end
        // Partial frame was lost: a bare eop is now outside any frame.
        drive(1, 0, 1, 0, 0, 64'h0);
        @(posedge clk); #1;
        check("post_rst_eop_dropped", err_only());
        drive(0, 0, 0, 0, 0, 64'h0);
        @(posedge clk); #1;
        check("post_rst_quiet", NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
